// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared types and encodings for the multicycle RISC-V core
package rv_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_ILLEGAL
  } mc_state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/rv_alu_decoder.sv
// rtl/rv_alu_decoder.sv - maps aluop/funct fields to the 3-bit ALU control
module rv_alu_decoder
  import rv_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alucontrol_o,
  output logic       unsupported_o
);

  // sltu has no ALU encoding; flagged independently of aluop so DECODE can trap it
  assign unsupported_o = (funct3_i == 3'b011);

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alucontrol_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alucontrol_o = ALU_SLL;
          3'b010:  alucontrol_o = ALU_SLT;
          3'b100:  alucontrol_o = ALU_XOR;
          3'b101:  alucontrol_o = ALU_SRL;
          3'b110:  alucontrol_o = ALU_OR;
          3'b111:  alucontrol_o = ALU_AND;
          default: alucontrol_o = ALU_ADD;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv_mc_controller.sv
// rtl/rv_mc_controller.sv - multicycle control FSM driving datapath enables and selects
module rv_mc_controller
  import rv_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic       regwrite,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  mc_state_t state_q, state_d;
  logic [1:0] aluop;
  logic       unsupported;
  logic       pcwrite_raw, memwrite_raw, irwrite_raw, regwrite_raw;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    pcwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    adrsrc       = 1'b0;
    resultsrc    = 2'b00;
    alusrca      = 2'b00;
    alusrcb      = 2'b00;
    aluop        = ALUOP_ADD;
    illegal      = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwrite_raw = 1'b1;
        pcwrite_raw = 1'b1;
        alusrcb     = 2'b10;
        resultsrc   = 2'b10;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut captures PC+imm here so BEQ can load it without another add
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = unsupported ? S_ILLEGAL : S_EXECUTER;
          OP_ITYPE:          state_d = unsupported ? S_ILLEGAL : S_EXECUTEI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrsrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc    = 2'b01;
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc       = 1'b1;
        memwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end
      S_EXECUTER: begin
        alusrca = 2'b10;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end
      S_BEQ: begin
        alusrca     = 2'b10;
        aluop       = ALUOP_SUB;
        pcwrite_raw = zero;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alusrca     = 2'b01;
        alusrcb     = 2'b10;
        pcwrite_raw = 1'b1;
        state_d     = S_ALUWB;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        state_d = S_ILLEGAL;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    immsrc = 2'b00;
    case (op)
      OP_STORE:  immsrc = 2'b01;
      OP_BRANCH: immsrc = 2'b10;
      OP_JAL:    immsrc = 2'b11;
      default:   immsrc = 2'b00;
    endcase
  end

  // write enables are suppressed during the reset cycle so an aborted instruction has no side effect
  assign pcwrite  = pcwrite_raw  & reset_n;
  assign memwrite = memwrite_raw & reset_n;
  assign irwrite  = irwrite_raw  & reset_n;
  assign regwrite = regwrite_raw & reset_n;

  rv_alu_decoder u_alu_decoder (
    .aluop_i       (aluop),
    .funct3_i      (funct3),
    .op5_i         (op[5]),
    .funct7b5_i    (funct7b5),
    .alucontrol_o  (alucontrol),
    .unsupported_o (unsupported)
  );

endmodule

// File: tb/tb_rv_mc_controller.sv
// tb/tb_rv_mc_controller.sv - scoreboard bench for the multicycle control unit
module tb_rv_mc_controller;

  localparam int T_F   = 0;
  localparam int T_D   = 1;
  localparam int T_MA  = 2;
  localparam int T_MR  = 3;
  localparam int T_MWB = 4;
  localparam int T_MW  = 5;
  localparam int T_ER  = 6;
  localparam int T_EI  = 7;
  localparam int T_AW  = 8;
  localparam int T_BEQ = 9;
  localparam int T_JAL = 10;
  localparam int T_IL  = 11;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [16:0] v;
  } sb_t;
  sb_t sb_q[$];

  rv_mc_controller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .pcwrite    (pcwrite),
    .adrsrc     (adrsrc),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .resultsrc  (resultsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .regwrite   (regwrite),
    .immsrc     (immsrc),
    .alucontrol (alucontrol),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  wire [16:0] dut_vec = {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca,
                         alusrcb, regwrite, immsrc, alucontrol, illegal};

  function automatic logic [2:0] ref_funct(input logic [2:0] f3, input logic op5, input logic f7);
    case (f3)
      3'b000:  return (op5 && f7) ? 3'b001 : 3'b000;
      3'b001:  return 3'b110;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b101:  return 3'b111;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // expected outputs from the state table; bit order matches dut_vec
  function automatic logic [16:0] ref_out(input int s, input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z, input logic rn);
    logic       pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sb, im;
    logic [2:0] ac;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; ac = 3'b000;
    case (s)
      T_F:   begin irw = 1; pcw = 1; sb = 2'b10; rs = 2'b10; end
      T_D:   begin sa = 2'b01; sb = 2'b01; end
      T_MA:  begin sa = 2'b10; sb = 2'b01; end
      T_MR:  adr = 1;
      T_MWB: begin rs = 2'b01; rw = 1; end
      T_MW:  begin adr = 1; mw = 1; end
      T_ER:  begin sa = 2'b10; ac = ref_funct(f3, o[5], f7); end
      T_EI:  begin sa = 2'b10; sb = 2'b01; ac = ref_funct(f3, o[5], f7); end
      T_AW:  rw = 1;
      T_BEQ: begin sa = 2'b10; ac = 3'b001; pcw = z; end
      T_JAL: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      T_IL:  ill = 1;
      default: ;
    endcase
    case (o)
      7'b0100011: im = 2'b01;
      7'b1100011: im = 2'b10;
      7'b1101111: im = 2'b11;
      default:    im = 2'b00;
    endcase
    if (!rn) begin pcw = 0; irw = 0; mw = 0; rw = 0; end
    return {pcw, adr, mw, irw, rs, sa, sb, rw, im, ac, ill};
  endfunction

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // push expectation for the current cycle, compare at the falling edge, then advance
  task automatic cyc(input int s, input string tag);
    sb_t e;
    e.tag = tag;
    e.v   = ref_out(s, op, funct3, funct7b5, zero, reset_n);
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    check(e.tag, dut_vec, e.v);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3_list [6];
    f3_list = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
    reset_n = 1'b0; zero = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0);
    @(posedge clk); #1;
    repeat (3) cyc(T_F, "reset_hold");
    reset_n = 1'b1;
    cyc(T_F, "first_fetch");
    cyc(T_D, "radd_decode"); cyc(T_ER, "radd_exec"); cyc(T_AW, "radd_wb");

    set_instr(7'b0000011, 3'b010, 1'b0);
    cyc(T_F, "lw_f"); cyc(T_D, "lw_d"); cyc(T_MA, "lw_memadr");
    cyc(T_MR, "lw_memread"); cyc(T_MWB, "lw_memwb");

    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc(T_F, "sw_f"); cyc(T_D, "sw_d"); cyc(T_MA, "sw_memadr"); cyc(T_MW, "sw_memwrite");

    set_instr(7'b0110011, 3'b000, 1'b1);
    cyc(T_F, "rsub_f"); cyc(T_D, "rsub_d"); cyc(T_ER, "rsub_exec"); cyc(T_AW, "rsub_wb");
    set_instr(7'b0010011, 3'b000, 1'b1);
    cyc(T_F, "iadd_f"); cyc(T_D, "iadd_d"); cyc(T_EI, "iadd_exec"); cyc(T_AW, "iadd_wb");

    foreach (f3_list[i]) begin
      set_instr(7'b0110011, f3_list[i], 1'b1);
      cyc(T_F, "rfn_f"); cyc(T_D, "rfn_d"); cyc(T_ER, "rfn_exec"); cyc(T_AW, "rfn_wb");
      set_instr(7'b0010011, f3_list[i], 1'b0);
      cyc(T_F, "ifn_f"); cyc(T_D, "ifn_d"); cyc(T_EI, "ifn_exec"); cyc(T_AW, "ifn_wb");
    end

    set_instr(7'b1100011, 3'b000, 1'b0);
    cyc(T_F, "beq1_f"); cyc(T_D, "beq1_d");
    zero = 1'b1; cyc(T_BEQ, "beq_taken"); zero = 1'b0;
    cyc(T_F, "beq0_f"); cyc(T_D, "beq0_d"); cyc(T_BEQ, "beq_not_taken");

    set_instr(7'b1101111, 3'b000, 1'b0);
    cyc(T_F, "jal_f"); cyc(T_D, "jal_d"); cyc(T_JAL, "jal_exec"); cyc(T_AW, "jal_wb");

    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc(T_F, "swr_f"); cyc(T_D, "swr_d"); cyc(T_MA, "swr_memadr");
    reset_n = 1'b0; cyc(T_MW, "sw_reset_abort"); reset_n = 1'b1;
    cyc(T_F, "swr_refetch"); cyc(T_D, "swr2_d"); cyc(T_MA, "swr2_memadr"); cyc(T_MW, "swr2_memwrite");

    set_instr(7'b0110111, 3'b000, 1'b0);
    cyc(T_F, "lui_f"); cyc(T_D, "lui_d");
    repeat (20) cyc(T_IL, "lui_illegal");
    reset_n = 1'b0; cyc(T_IL, "illegal_reset"); reset_n = 1'b1;

    set_instr(7'b0110011, 3'b011, 1'b0);
    cyc(T_F, "sltu_f"); cyc(T_D, "sltu_d");
    repeat (3) cyc(T_IL, "sltu_illegal");
    reset_n = 1'b0; cyc(T_IL, "sltu_reset"); reset_n = 1'b1;
    set_instr(7'b0010011, 3'b011, 1'b0);
    cyc(T_F, "sltiu_f"); cyc(T_D, "sltiu_d"); cyc(T_IL, "sltiu_illegal");
    reset_n = 1'b0; cyc(T_IL, "sltiu_reset"); reset_n = 1'b1;
    cyc(T_F, "final_fetch");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
